// File: rtl/systolic_pkg.sv
// Shared helpers for the systolic array datapath: result-lane width,
// ceiling log2 and packed-row lane addressing.
package systolic_pkg;

    localparam int DEFAULT_DATA_WIDTH = 4;

    function automatic int sumWidth(input int dataWidth);
        return dataWidth * dataWidth;
    endfunction

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    function automatic int laneLsb(input int lane, input int laneWidth);
        return lane * laneWidth;
    endfunction

    localparam int DEFAULT_SUM_WIDTH = sumWidth(DEFAULT_DATA_WIDTH);

    typedef logic signed [DEFAULT_SUM_WIDTH-1:0] sumLane_t;

endpackage

// File: rtl/systolic_drain_if.sv
// Bundle between the array's skewed output row, the drain and the consumer of
// aligned rows. The array side is the master, the drain is the slave.
interface systolic_drain_if
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE = 4,
    parameter int DATA_WIDTH = 4,
    parameter int FIFO_DEPTH = 4
);
    localparam int ROW_WIDTH = ARRAY_SIZE * sumWidth(DATA_WIDTH);
    localparam int CNT_WIDTH = clog2(FIFO_DEPTH) + 1;

    logic                 in_valid;
    logic [ROW_WIDTH-1:0] sum_in;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [ROW_WIDTH-1:0] out_row;
    logic [CNT_WIDTH-1:0] count;
    logic                 overflow;

    modport master (
        output in_valid,
        output sum_in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_row,
        input  count,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  sum_in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_row,
        output count,
        output overflow
    );

endinterface

// File: rtl/sum_delay_line.sv
// Fixed-latency register chain for one result lane; a DEPTH of zero is a plain wire.
module sum_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    if (DEPTH == 0) begin : g_wire
        logic w_unusedClockReset;
        assign w_unusedClockReset = clk ^ reset;
        assign o_data = i_data;
    end else begin : g_chain
        logic [WIDTH-1:0] r_stage [DEPTH];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_stage[i] <= '0;
                end
            end else begin
                r_stage[0] <= i_data;
                for (int i = 1; i < DEPTH; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign o_data = r_stage[DEPTH-1];
    end

endmodule

// File: rtl/systolic_drain.sv
// De-skews the time-skewed bottom row of the systolic array into aligned rows and
// buffers them in a small FIFO. Define SYSTOLIC_DRAIN_RELU_EN to clamp negative output lanes to zero.
module systolic_drain
    import systolic_pkg::*;
#(
    parameter int ARRAY_SIZE = 4,
    parameter int DATA_WIDTH = 4,
    parameter int FIFO_DEPTH = 4
) (
    input logic             clk,
    input logic             reset,
    systolic_drain_if.slave bus
);

    localparam int SUM_WIDTH = sumWidth(DATA_WIDTH);
    localparam int ROW_WIDTH = ARRAY_SIZE * SUM_WIDTH;
    localparam int PTR_WIDTH = clog2(FIFO_DEPTH);
    localparam int CNT_WIDTH = PTR_WIDTH + 1;
    localparam int SR_LEN    = ARRAY_SIZE - 1;

    logic [ROW_WIDTH-1:0] w_alignedRow;
    logic [ROW_WIDTH-1:0] w_head;
    logic [SR_LEN-1:0]    r_validSr;
    logic [ROW_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0] r_wrPtr;
    logic [PTR_WIDTH-1:0] r_rdPtr;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_overflow;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_notEmpty;
    logic                 w_write;
    logic                 w_drop;
    int                   w_inflight;

    // Lane j arrives j cycles late, so it is delayed by the remaining skew.
    for (genvar j = 0; j < ARRAY_SIZE; j++) begin : g_lane
        sum_delay_line #(
            .DEPTH (ARRAY_SIZE - 1 - j),
            .WIDTH (SUM_WIDTH)
        ) u_delay (
            .clk    (clk),
            .reset  (reset),
            .i_data (bus.sum_in[laneLsb(j, SUM_WIDTH) +: SUM_WIDTH]),
            .o_data (w_alignedRow[laneLsb(j, SUM_WIDTH) +: SUM_WIDTH])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_validSr <= '0;
        end else begin
            r_validSr[0] <= bus.in_valid;
            for (int i = 1; i < SR_LEN; i++) begin
                r_validSr[i] <= r_validSr[i-1];
            end
        end
    end

    always_comb begin
        w_inflight = 0;
        for (int i = 0; i < SR_LEN; i++) begin
            w_inflight = w_inflight + int'(r_validSr[i]);
        end
    end

    assign w_push     = r_validSr[SR_LEN-1];
    assign w_full     = (r_count == CNT_WIDTH'(FIFO_DEPTH));
    assign w_notEmpty = (r_count != '0);
    assign w_pop      = w_notEmpty && bus.out_ready;
    // A pop frees the slot in the same edge, so a full FIFO still accepts the push.
    assign w_write    = w_push && (!w_full || w_pop);
    assign w_drop     = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write) begin
                r_mem[r_wrPtr] <= w_alignedRow;
                r_wrPtr        <= r_wrPtr + PTR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_WIDTH'(1);
            end
            if (w_write && !w_pop) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end else if (!w_write && w_pop) begin
                r_count <= r_count - CNT_WIDTH'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_head       = r_mem[r_rdPtr];
    assign bus.in_ready  = (int'(r_count) + w_inflight) < FIFO_DEPTH;
    assign bus.out_valid = w_notEmpty;
    assign bus.count     = r_count;
    assign bus.overflow  = r_overflow;

`ifdef SYSTOLIC_DRAIN_RELU_EN
    always_comb begin
        bus.out_row = w_head;
        for (int j = 0; j < ARRAY_SIZE; j++) begin
            if (w_head[laneLsb(j, SUM_WIDTH) + SUM_WIDTH - 1]) begin
                bus.out_row[laneLsb(j, SUM_WIDTH) +: SUM_WIDTH] = '0;
            end
        end
    end
`else
    assign bus.out_row = w_head;
`endif

endmodule

// File: tb/tb_systolic_drain.sv
// Directed bench for systolic_drain: skewed row injection, alignment, credit,
// overflow and reset behaviour, with expectations adjusted for the RELU build.
module tb_systolic_drain;
    import systolic_pkg::*;

    localparam int ARRAY_SIZE = 4;
    localparam int DATA_WIDTH = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int LANE_W     = sumWidth(DATA_WIDTH);
    localparam int ROW_W      = ARRAY_SIZE * LANE_W;
    localparam int SCHED      = 256;

    logic clk;
    logic reset;
    int   cyc;
    int   errors;
    int   checks;

    int       validAt [SCHED];
    int       laneAt  [SCHED][ARRAY_SIZE];
    sumLane_t laneVal [SCHED][ARRAY_SIZE];

    systolic_drain_if #(
        .ARRAY_SIZE (ARRAY_SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) bus ();

    systolic_drain #(
        .ARRAY_SIZE (ARRAY_SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Replays the scheduled skewed lanes; unscheduled lanes carry random garbage.
    initial begin
        int idx;
        cyc          = 0;
        bus.in_valid = 1'b0;
        bus.sum_in   = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc          = cyc + 1;
            idx          = cyc % SCHED;
            bus.in_valid = (validAt[idx] == cyc);
            for (int j = 0; j < ARRAY_SIZE; j++) begin
                if (laneAt[idx][j] == cyc) begin
                    bus.sum_in[j*LANE_W +: LANE_W] = laneVal[idx][j];
                end else begin
                    bus.sum_in[j*LANE_W +: LANE_W] = LANE_W'($urandom);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [ROW_W-1:0] makeRow(input int l0, input int l1, input int l2, input int l3);
        return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
    endfunction

    function automatic logic [ROW_W-1:0] bpRow(input int k);
        return makeRow(512 + k, -(k + 1), 768 + k, -(64 + k));
    endfunction

    function automatic logic [ROW_W-1:0] expOut(input logic [ROW_W-1:0] raw);
        logic [ROW_W-1:0] result;
        result = raw;
`ifdef SYSTOLIC_DRAIN_RELU_EN
        for (int j = 0; j < ARRAY_SIZE; j++) begin
            if (raw[j*LANE_W + LANE_W - 1]) begin
                result[j*LANE_W +: LANE_W] = '0;
            end
        end
`endif
        return result;
    endfunction

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) begin
            nextCycle();
        end
    endtask

    task automatic applyStimulus(input int start, input logic [ROW_W-1:0] row);
        validAt[start % SCHED] = start;
        for (int j = 0; j < ARRAY_SIZE; j++) begin
            laneAt[(start + j) % SCHED][j]  = start + j;
            laneVal[(start + j) % SCHED][j] = row[j*LANE_W +: LANE_W];
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.out_ready = 1'b0;
        repeat (3) nextCycle();
        reset = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", bus.in_ready); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
        checks++;
        if (bus.out_row !== '0) begin errors++; $display("[TB] FAIL reset_out_row: got %h, expected 0", bus.out_row); end
        checks++;
        if (bus.count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d, expected 0", bus.count); end
        checks++;
        if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_overflow: got %b, expected 0", bus.overflow); end
    endtask

    task automatic test_single_row();
        int s;
        logic [ROW_W-1:0] row;
        row = makeRow(5, -3, 7, 100);
        s = cyc + 2;
        applyStimulus(s, row);
        waitUntil(s + 3);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_early_valid: got %b, expected 0", bus.out_valid); end
        nextCycle();
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %b, expected 1", bus.out_valid); end
        checks++;
        if (bus.out_row !== expOut(row)) begin errors++; $display("[TB] FAIL single_row: got %h, expected %h", bus.out_row, expOut(row)); end
        checks++;
        if (bus.count !== 3'd1) begin errors++; $display("[TB] FAIL single_count: got %0d, expected 1", bus.count); end
        bus.out_ready = 1'b1;
        nextCycle();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.count !== 3'd0) begin errors++; $display("[TB] FAIL single_count_after_pop: got %0d, expected 0", bus.count); end
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_valid_after_pop: got %b, expected 0", bus.out_valid); end
    endtask

    task automatic test_streaming();
        int s;
        logic [ROW_W-1:0] row;
        bus.out_ready = 1'b1;
        s = cyc + 2;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(s + k, makeRow(16*k, 16*k + 1, 16*k + 2, 16*k + 3));
        end
        waitUntil(s + 4);
        checks++;
        if (bus.count !== 3'd1) begin errors++; $display("[TB] FAIL stream_count: got %0d, expected 1", bus.count); end
        for (int k = 0; k < 8; k++) begin
            waitUntil(s + 4 + k);
            row = makeRow(16*k, 16*k + 1, 16*k + 2, 16*k + 3);
            checks++;
            if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stream_valid_%0d: got %b, expected 1", k, bus.out_valid); end
            checks++;
            if (bus.out_row !== expOut(row)) begin errors++; $display("[TB] FAIL stream_row_%0d: got %h, expected %h", k, bus.out_row, expOut(row)); end
        end
        waitUntil(s + 12);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_drained: got %b, expected 0", bus.out_valid); end
        checks++;
        if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL stream_overflow: got %b, expected 0", bus.overflow); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int s;
        bus.out_ready = 1'b0;
        s = cyc + 2;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(s + k, bpRow(k));
        end
        waitUntil(s + 3);
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_at_fourth: got %b, expected 1", bus.in_ready); end
        nextCycle();
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_after_fourth: got %b, expected 0", bus.in_ready); end
        waitUntil(s + 7);
        checks++;
        if (bus.count !== 3'd4) begin errors++; $display("[TB] FAIL bp_count: got %0d, expected 4", bus.count); end
        checks++;
        if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL bp_overflow: got %b, expected 0", bus.overflow); end
        checks++;
        if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_full: got %b, expected 0", bus.in_ready); end
    endtask

    task automatic test_overflow();
        int s;
        s = cyc + 1;
        applyStimulus(s, bpRow(4));
        waitUntil(s + 3);
        checks++;
        if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_before_drop: got %b, expected 0", bus.overflow); end
        nextCycle();
        checks++;
        if (bus.overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b, expected 1", bus.overflow); end
        checks++;
        if (bus.count !== 3'd4) begin errors++; $display("[TB] FAIL ovf_count: got %0d, expected 4", bus.count); end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.out_row !== expOut(bpRow(k))) begin errors++; $display("[TB] FAIL ovf_drain_row_%0d: got %h, expected %h", k, bus.out_row, expOut(bpRow(k))); end
            nextCycle();
        end
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ovf_no_fifth_row: got %b, expected 0", bus.out_valid); end
        checks++;
        if (bus.overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_sticky: got %b, expected 1", bus.overflow); end
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        checks++;
        if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_cleared_by_reset: got %b, expected 0", bus.overflow); end
    endtask

    task automatic test_full_push_pop();
        int s;
        bus.out_ready = 1'b0;
        s = cyc + 2;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(s + k, bpRow(8 + k));
        end
        applyStimulus(s + 5, bpRow(12));
        waitUntil(s + 8);
        checks++;
        if (bus.count !== 3'd4) begin errors++; $display("[TB] FAIL fpp_full_count: got %0d, expected 4", bus.count); end
        bus.out_ready = 1'b1;
        nextCycle();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.count !== 3'd4) begin errors++; $display("[TB] FAIL fpp_count_kept: got %0d, expected 4", bus.count); end
        checks++;
        if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL fpp_overflow: got %b, expected 0", bus.overflow); end
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (bus.out_row !== expOut(bpRow(8 + k))) begin errors++; $display("[TB] FAIL fpp_drain_row_%0d: got %h, expected %h", k, bus.out_row, expOut(bpRow(8 + k))); end
            nextCycle();
        end
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fpp_drained: got %b, expected 0", bus.out_valid); end
    endtask

    task automatic test_reset_midflight();
        int s;
        logic stale;
        bus.out_ready = 1'b0;
        s = cyc + 2;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(s + k, makeRow(5 + k, -3, 7, 100 + k));
        end
        waitUntil(s + 5);
        checks++;
        if (bus.count !== 3'd2) begin errors++; $display("[TB] FAIL mid_count_before: got %0d, expected 2", bus.count); end
        checks++;
        if (bus.out_row !== expOut(makeRow(5, -3, 7, 100))) begin errors++; $display("[TB] FAIL mid_head_row: got %h, expected %h", bus.out_row, expOut(makeRow(5, -3, 7, 100))); end
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_out_valid: got %b, expected 0", bus.out_valid); end
        checks++;
        if (bus.count !== 3'd0) begin errors++; $display("[TB] FAIL mid_count: got %0d, expected 0", bus.count); end
        checks++;
        if (bus.overflow !== 1'b0) begin errors++; $display("[TB] FAIL mid_overflow: got %b, expected 0", bus.overflow); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_in_ready: got %b, expected 1", bus.in_ready); end
        checks++;
        if (bus.out_row !== '0) begin errors++; $display("[TB] FAIL mid_out_row: got %h, expected 0", bus.out_row); end
        stale = 1'b0;
        repeat (8) begin
            nextCycle();
            if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) stale = 1'b1;
        end
        checks++;
        if (stale !== 1'b0) begin errors++; $display("[TB] FAIL mid_stale_row: got stale=%b, expected 0", stale); end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        reset         = 1'b1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < SCHED; i++) begin
            validAt[i] = -1;
            for (int j = 0; j < ARRAY_SIZE; j++) begin
                laneAt[i][j]  = -1;
                laneVal[i][j] = '0;
            end
        end
        $display("[TB] starting systolic_drain bench");
        test_reset();
        test_single_row();
        test_streaming();
        test_backpressure();
        test_overflow();
        test_full_push_pop();
        test_reset_midflight();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
